// File: rtl/rc5_pkg.sv
// rc5_pkg: shared RC5-16 key schedule constants, widths, state enum and word type
package rc5_pkg;
  localparam int W = 16;
  localparam int KEY_BITS = 128;
  localparam int ROUNDS = 16;
  localparam int T = 2 * (ROUNDS + 1);
  localparam int C = KEY_BITS / W;
  localparam int N = 3 * (T > C ? T : C);
  localparam int KW = $clog2(T);
  localparam int JW = $clog2(C);
  localparam int NW = $clog2(N);
  localparam int RW = $clog2(W);
  localparam logic [W-1:0] P16 = 16'hB7E1;
  localparam logic [W-1:0] Q16 = 16'h9E37;
  typedef enum logic [1:0] {IDLE, INIT, MIX, DONE} state_t;
  typedef logic [W-1:0] subkey_t;
endpackage

// File: rtl/rc5_key_expander_if.sv
// rc5_key_expander_if: host-side bundle (start, key in; busy, ready, sub_o out) with master/slave modports
interface rc5_key_expander_if;
  import rc5_pkg::*;
  logic start;
  logic [KEY_BITS-1:0] key;
  logic busy;
  logic ready;
  logic [T*W-1:0] sub_o;
  modport master(output start, key, input busy, ready, sub_o);
  modport slave(input start, key, output busy, ready, sub_o);
endinterface

// File: rtl/rc5_key_expander_rotl.sv
// rotl: W-bit rotate left of data_i by n_i, result on data_o
module rotl #(
  parameter int W = 16
) (
  input  logic [W-1:0]         data_i,
  input  logic [$clog2(W)-1:0] n_i,
  output logic [W-1:0]         data_o
);
  logic [2*W-1:0] dbl;
  assign dbl = {data_i, data_i} << n_i;
  assign data_o = dbl[2*W-1:W];
endmodule

// File: rtl/rc5_key_expander.sv
// rc5_key_expander: sequential RC5-16 key schedule; clk, rst (sync, active-low), bus = start/key in, busy/ready/sub_o out
module rc5_key_expander
  import rc5_pkg::*;
(
  input logic clk,
  input logic rst,
  rc5_key_expander_if.slave bus
);
  localparam logic [KW-1:0] K_LAST = KW'(T - 1);
  localparam logic [JW-1:0] J_LAST = JW'(C - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N - 1);
  state_t state_q, state_d;
  subkey_t s_q [T];
  subkey_t s_d [T];
  subkey_t l_q [C];
  subkey_t l_d [C];
  logic [KW-1:0] k_q, k_d;
  logic [JW-1:0] j_q, j_d;
  logic [NW-1:0] n_q, n_d;
  subkey_t a_q, a_d, b_q, b_d;
  subkey_t a_n, b_n, ab, wdata;
  logic we;
  rotl #(.W(W)) u_rot_a (.data_i(s_q[k_q] + a_q + b_q), .n_i(RW'(3)), .data_o(a_n));
  assign ab = a_n + b_q;
  rotl #(.W(W)) u_rot_b (.data_i(l_q[j_q] + ab), .n_i(ab[RW-1:0]), .data_o(b_n));
  always_comb begin
    state_d = state_q;
    s_d = s_q;
    l_d = l_q;
    k_d = k_q;
    j_d = j_q;
    n_d = n_q;
    a_d = a_q;
    b_d = b_q;
    we = 1'b0;
    wdata = '0;
    unique case (state_q)
      IDLE, DONE: if (bus.start) begin
        state_d = INIT;
        k_d = '0;
        for (int c = 0; c < C; c++) l_d[c] = bus.key[W*c +: W];
      end
      INIT: begin
        we = 1'b1;
        wdata = P16 + subkey_t'(k_q) * Q16;
        k_d = k_q == K_LAST ? '0 : k_q + KW'(1);
        if (k_q == K_LAST) begin
          state_d = MIX;
          j_d = '0;
          n_d = '0;
          a_d = '0;
          b_d = '0;
        end
      end
      MIX: begin
        we = 1'b1;
        wdata = a_n;
        a_d = a_n;
        b_d = b_n;
        l_d[j_q] = b_n;
        k_d = k_q == K_LAST ? '0 : k_q + KW'(1);
        j_d = j_q == J_LAST ? '0 : j_q + JW'(1);
        n_d = n_q + NW'(1);
        state_d = n_q == N_LAST ? DONE : MIX;
      end
      default: ;
    endcase
    if (we) s_d[k_q] = wdata;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      s_q <= '{default: '0};
      l_q <= '{default: '0};
      k_q <= '0;
      j_q <= '0;
      n_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      l_q <= l_d;
      k_q <= k_d;
      j_q <= j_d;
      n_q <= n_d;
      a_q <= a_d;
      b_q <= b_d;
    end
  end
  assign bus.busy = state_q == INIT || state_q == MIX;
  assign bus.ready = state_q == DONE;
  for (genvar g = 0; g < T; g++) assign bus.sub_o[W*g +: W] = s_q[g];
endmodule

// File: tb/tb_rc5_key_expander.sv
// tb_rc5_key_expander: randomized self-checking bench against a reference RC5-16 key schedule
module tb_rc5_key_expander;
  import rc5_pkg::*;
  localparam int DW = T * W;
  localparam int LAT = T + N;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  rc5_key_expander_if bus();
  rc5_key_expander dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic logic [15:0] rl(input logic [15:0] x, input int n);
    return 16'((x << n) | (x >> (16 - n)));
  endfunction
  function automatic logic [DW-1:0] model(input logic [127:0] key);
    logic [15:0] s [34];
    logic [15:0] l [8];
    logic [15:0] a, b;
    logic [DW-1:0] r;
    int i, j;
    for (int c = 0; c < 8; c++) l[c] = key[16*c +: 16];
    for (int t = 0; t < 34; t++) s[t] = 16'(32'hB7E1 + t * 32'h9E37);
    a = 0;
    b = 0;
    i = 0;
    j = 0;
    for (int n = 0; n < 3 * 34; n++) begin
      a = rl(s[i] + a + b, 3);
      s[i] = a;
      b = rl(l[j] + a + b, int'((a + b) % 16));
      l[j] = b;
      i = (i + 1) % 34;
      j = (j + 1) % 8;
    end
    for (int t = 0; t < 34; t++) r[16*t +: 16] = s[t];
    return r;
  endfunction
  function automatic logic [127:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic expand(input logic [127:0] k, input int inj, input logic [127:0] k2);
    int cnt;
    @(negedge clk);
    bus.key = k;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.key = rnd();
    chk("busy_after_start", DW'(bus.busy), DW'(1));
    chk("ready_after_start", DW'(bus.ready), DW'(0));
    cnt = 0;
    while (!bus.ready && cnt < 400) begin
      bus.start = cnt == inj;
      if (cnt == inj) bus.key = k2;
      @(posedge clk);
      #1;
      cnt++;
    end
    bus.start = 1'b0;
    chk("latency", DW'(cnt), DW'(LAT));
    chk("table", bus.sub_o, model(k));
  endtask
  initial begin
    logic [127:0] ks [3];
    int cnt;
    bus.start = 1'b0;
    bus.key = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", DW'(bus.busy), DW'(0));
    chk("reset_ready", DW'(bus.ready), DW'(0));
    chk("reset_sub", bus.sub_o, '0);
    @(negedge clk);
    rst = 1'b1;
    expand('0, -1, '0);
    expand(128'h0F0E0D0C0B0A09080706050403020100, -1, '0);
    for (int r = 0; r < 8; r++) expand(rnd(), -1, '0);
    expand(rnd(), T + 50, rnd());
    @(negedge clk);
    bus.key = rnd();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (T + 70) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_busy", DW'(bus.busy), DW'(0));
    chk("midrst_ready", DW'(bus.ready), DW'(0));
    chk("midrst_sub", bus.sub_o, '0);
    @(negedge clk);
    rst = 1'b1;
    expand(rnd(), -1, '0);
    for (int r = 0; r < 3; r++) ks[r] = rnd();
    @(negedge clk);
    bus.key = ks[0];
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    for (int r = 0; r < 3; r++) begin
      cnt = 0;
      while (!bus.ready && cnt < 400) begin
        @(posedge clk);
        #1;
        cnt++;
      end
      chk("b2b_latency", DW'(cnt), DW'(LAT));
      chk("b2b_table", bus.sub_o, model(ks[r]));
      if (r < 2) bus.key = ks[r+1];
      else bus.start = 1'b0;
      @(posedge clk);
      #1;
      chk("b2b_ready_next", DW'(bus.ready), DW'(r < 2 ? 0 : 1));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
